// File: rtl/div32_seq_ctrl_pkg.sv
// ============================================================================
// Package  : div32_seq_ctrl_pkg
// Brief    : Shared constants, state encoding and helpers for the divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div32_seq_ctrl_pkg;

   localparam int WIDTH      = 32;
   localparam int ITER_COUNT = 32;
   localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic [WIDTH-1:0] neg32(input logic [WIDTH-1:0] x);
      return ~x + 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sub_32_bit.sv
// ============================================================================
// Module   : sub_32_bit
// Brief    : 32-bit combinational subtractor, out = i1 - i2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_32_bit (
   input  logic [31:0] i1,
   input  logic [31:0] i2,
   output logic [31:0] out
);

   assign out = i1 - i2;

endmodule

`default_nettype wire

// File: rtl/div32_seq_ctrl.sv
// ============================================================================
// Module   : div32_seq_ctrl
// Brief    : Multicycle 32-bit restoring divider using one sub_32_bit.
// Options  : DIV_SIGNED_EN - adds signed operation with a sign-fix state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div32_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             signed_op,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   import div32_seq_ctrl_pkg::*;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_d;
   logic             r_dbz;

   logic             w_accept;
   logic             w_div_zero;
   logic             w_last;
   logic             w_fix_pend;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_s;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;

`ifdef DIV_SIGNED_EN
   logic r_fix;
   logic r_neg_q;
   logic r_neg_r;
   logic w_neg_a;
   logic w_neg_b;

   assign w_neg_a    = signed_op & dividend[WIDTH-1];
   assign w_neg_b    = signed_op & divisor[WIDTH-1];
   assign w_a_mag    = w_neg_a ? neg32(dividend) : dividend;
   assign w_b_mag    = w_neg_b ? neg32(divisor)  : divisor;
   assign w_fix_pend = r_fix;

   // Sign bookkeeping; FIX runs for every signed op, even when no negate is needed
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fix   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_accept) begin
         r_fix   <= signed_op & ~w_div_zero;
         r_neg_q <= w_neg_a ^ w_neg_b;
         r_neg_r <= w_neg_a;
      end
   end
`else
   logic w_unused_signed;

   assign w_unused_signed = signed_op;
   assign w_a_mag         = dividend;
   assign w_b_mag         = divisor;
   assign w_fix_pend      = 1'b0;
`endif

   assign ready      = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_accept   = start & ready;
   assign w_div_zero = (divisor == '0);
   assign w_last     = (r_cnt == CNT_W'(ITER_COUNT - 1));

   // Trial subtraction of the shifted partial remainder against the divisor
   assign w_s = {r_r, r_q[WIDTH-1]};

   sub_32_bit u_sub (
      .i1  (w_s[WIDTH-1:0]),
      .i2  (r_d),
      .out (w_diff)
   );

   assign w_ge = w_s[WIDTH]
               | (w_s[WIDTH-1] & ~r_d[WIDTH-1])
               | (~(w_s[WIDTH-1] ^ r_d[WIDTH-1]) & ~w_diff[WIDTH-1]);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_ITER;
            end
         end
         ST_ITER: begin
            // A zero divisor spends one ITER cycle without iterating
            if (r_dbz) begin
               w_state_nxt = ST_DONE;
            end else if (w_last) begin
               w_state_nxt = w_fix_pend ? ST_FIX : ST_DONE;
            end
         end
         ST_FIX: begin
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_state_nxt = start ? ST_ITER : ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt       <= '0;
         r_q         <= '0;
         r_r         <= '0;
         r_d         <= '0;
         r_dbz       <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;

         if (w_accept) begin
            r_cnt       <= '0;
            r_d         <= w_b_mag;
            r_dbz       <= w_div_zero;
            r_q         <= w_div_zero ? DBZ_QUOTIENT : w_a_mag;
            r_r         <= w_div_zero ? dividend : '0;
            div_by_zero <= 1'b0;
         end

         case (r_state)
            ST_ITER: begin
               if (!r_dbz) begin
                  r_r   <= w_ge ? w_diff : w_s[WIDTH-1:0];
                  r_q   <= {r_q[WIDTH-2:0], w_ge};
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`ifdef DIV_SIGNED_EN
            ST_FIX: begin
               r_q <= r_neg_q ? neg32(r_q) : r_q;
               r_r <= r_neg_r ? neg32(r_r) : r_r;
            end
`endif
            ST_DONE: begin
               // Publishes the finished op even if a new one is accepted this edge
               quotient    <= r_q;
               remainder   <= r_r;
               div_by_zero <= r_dbz;
               done        <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_div32_seq_ctrl.sv
// ============================================================================
// Module   : tb_div32_seq_ctrl
// Brief    : Randomized self-checking bench for div32_seq_ctrl (DIV_SIGNED_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div32_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        signed_op;
   logic        ready;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   div32_seq_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .signed_op   (signed_op),
      .ready       (ready),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Reference: plain arithmetic on the operands, plus the latency the op should take
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic dz, output int lat);
      dz  = (b == 32'd0);
      q   = a / (dz ? 32'd1 : b);
      r   = a % (dz ? 32'd1 : b);
      lat = 33;
      if (dz) begin
         q   = 32'hFFFF_FFFF;
         r   = a;
         lat = 2;
      end
`ifdef DIV_SIGNED_EN
      else if (s) begin
         lat = 34;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end
`endif
   endfunction

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!done && lat < 100);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
      logic [31:0] eq, er;
      logic        edz;
      int          elat, lat;
      model(a, b, s, eq, er, edz, elat);
      check({tag, " ready_idle"}, ready, 1);
      dividend  = a;
      divisor   = b;
      signed_op = s;
      start     = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      check({tag, " ready_busy"}, ready, 0);
      wait_done(lat);
      check({tag, " latency"}, lat, elat);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " dbz"}, div_by_zero, edz);
      check({tag, " ready_done"}, ready, 1);
      @(posedge clk); #1;
      check({tag, " done_pulse"}, done, 0);
   endtask

   initial begin
      int lat, dones;
      logic [31:0] a, b;
      reset     = 1'b1;
      start     = 1'b0;
      dividend  = '0;
      divisor   = '0;
      signed_op = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst ready", ready, 1);
      check("rst done", done, 0);
      check("rst quotient", quotient, 0);
      check("rst remainder", remainder, 0);
      check("rst dbz", div_by_zero, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_op(32'd100, 32'd7, 1'b0, "u100/7");
      run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "uwide");
      run_op(32'd5, 32'd0, 1'b0, "dbz5");
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7/2");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "smin/-1");
      run_op(32'hFFFF_FFF9, 32'd0, 1'b1, "sdbz");
      run_op(32'd3, 32'd1000, 1'b0, "small/big");

      for (int i = 0; i < 20; i++) begin
         int sel;
         sel = $urandom_range(0, 9);
         a   = $urandom;
         b   = (sel == 0) ? 32'd0 : (sel < 5) ? 32'($urandom_range(1, 255)) : $urandom;
         run_op(a, b, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      end

      // Back-to-back: start stays high through the first op's completion
      dividend  = 32'd9;
      divisor   = 32'd2;
      signed_op = 1'b0;
      start     = 1'b1;
      @(posedge clk); #1;
      dividend = 32'd10;
      divisor  = 32'd5;
      wait_done(lat);
      check("b2b1 latency", lat, 33);
      check("b2b1 quotient", quotient, 4);
      check("b2b1 remainder", remainder, 1);
      start = 1'b0;
      wait_done(lat);
      check("b2b2 latency", lat, 33);
      check("b2b2 quotient", quotient, 2);
      check("b2b2 remainder", remainder, 0);
      @(posedge clk); #1;

      // Mid-operation restart attempt and reset
      run_op(32'd1000, 32'd3, 1'b0, "u1000/3");
      dividend = 32'd1000;
      divisor  = 32'd3;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0;
      repeat (4) begin
         @(posedge clk); #1;
         dones += int'(done);
      end
      dividend = 32'd50;
      divisor  = 32'd5;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy start ignored", ready, 0);
      repeat (4) begin
         @(posedge clk); #1;
         dones += int'(done);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst ready", ready, 1);
      check("midrst done", done, 0);
      check("midrst quotient", quotient, 0);
      check("midrst remainder", remainder, 0);
      check("midrst dbz", div_by_zero, 0);
      repeat (40) begin
         @(posedge clk); #1;
         dones += int'(done);
      end
      check("midrst no done", dones, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
